// File: rtl/axis_pkt_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for the AXIS packet arbiter.
// The pick function is sized for the largest supported source count.
package axis_pkt_rr_arbiter_pkg;

    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} arb_state_t;

    localparam int RR_MAX_SRC = 16;
    localparam int RR_PTR_W   = 4;

    // First requester found scanning ptr, ptr+1, ... modulo n.
    function automatic logic [RR_PTR_W-1:0] rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                                    input logic [RR_PTR_W-1:0]   ptr,
                                                    input int                    n);
        logic [RR_PTR_W-1:0] win;
        logic                found;
        int                  idx;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < RR_MAX_SRC; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx[RR_PTR_W-1:0]]) begin
                win   = idx[RR_PTR_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_pkt_rr_arbiter_skid_buf.sv
// Two-entry AXI4-Stream register slice with a registered s_tready.
// Entry 0 drives the master side directly; entry 1 absorbs the beat in flight when the consumer stalls.
module axis_skid_buf #(
    parameter int TDATA_W = 32,
    parameter int TUSER_W = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic [TDATA_W-1:0] s_tdata,
    input  logic [TUSER_W-1:0] s_tuser,
    input  logic               s_tlast,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [TDATA_W-1:0] m_tdata,
    output logic [TUSER_W-1:0] m_tuser,
    output logic               m_tlast
);
    localparam int PW = TDATA_W + TUSER_W + 1;

    logic [PW-1:0] r_ent0, r_ent1;
    logic          r_vld0, r_vld1, r_rdy;
    logic [PW-1:0] w_in, w_ent0_nxt, w_ent1_nxt;
    logic          w_push, w_pop, w_vld0_nxt, w_vld1_nxt;

    assign w_in   = {s_tdata, s_tuser, s_tlast};
    assign w_push = s_tvalid & r_rdy;
    assign w_pop  = r_vld0 & m_tready;

    // Shift out first, then the incoming beat lands in the lowest free slot.
    always_comb begin
        w_ent0_nxt = r_ent0;
        w_ent1_nxt = r_ent1;
        w_vld0_nxt = r_vld0;
        w_vld1_nxt = r_vld1;
        if (w_pop) begin
            w_ent0_nxt = r_ent1;
            w_vld0_nxt = r_vld1;
            w_vld1_nxt = 1'b0;
        end
        if (w_push) begin
            if (!w_vld0_nxt) begin
                w_ent0_nxt = w_in;
                w_vld0_nxt = 1'b1;
            end else begin
                w_ent1_nxt = w_in;
                w_vld1_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_vld0 <= 1'b0;
            r_vld1 <= 1'b0;
            r_rdy  <= 1'b1;
        end else begin
            r_ent0 <= w_ent0_nxt;
            r_ent1 <= w_ent1_nxt;
            r_vld0 <= w_vld0_nxt;
            r_vld1 <= w_vld1_nxt;
            r_rdy  <= !w_vld1_nxt;
        end
    end

    assign {m_tdata, m_tuser, m_tlast} = r_ent0;
    assign m_tvalid = r_vld0;
    assign s_tready = r_rdy;

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// N:1 AXI4-Stream packet arbiter: round-robin grant held for a whole packet,
// merged stream registered through a two-entry skid buffer.
module axis_pkt_rr_arbiter
    import axis_pkt_rr_arbiter_pkg::*;
#(
    parameter  int N_SRC   = 4,
    parameter  int TDATA_W = 32,
    parameter  int TUSER_W = 1,
    localparam int IDX_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       arb_en,
    input  logic [N_SRC-1:0]           s_tvalid,
    output logic [N_SRC-1:0]           s_tready,
    input  logic [N_SRC*TDATA_W-1:0]   s_tdata,
    input  logic [N_SRC*TUSER_W-1:0]   s_tuser,
    input  logic [N_SRC-1:0]           s_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [TDATA_W-1:0]         m_tdata,
    output logic [TUSER_W-1:0]         m_tuser,
    output logic                       m_tlast,
    output logic                       grant_vld,
    output logic [IDX_W-1:0]           grant_idx
);
    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_grant_idx, r_rr_ptr;
    logic               r_grant_vld;

    logic               w_sel_vld, w_sel_last, w_skid_vld, w_skid_rdy, w_beat;
    logic [TDATA_W-1:0] w_sel_data;
    logic [TUSER_W-1:0] w_sel_user;

    assign w_sel_vld  = s_tvalid[r_grant_idx];
    assign w_sel_last = s_tlast[r_grant_idx];
    assign w_sel_data = s_tdata[r_grant_idx*TDATA_W +: TDATA_W];
    assign w_sel_user = s_tuser[r_grant_idx*TUSER_W +: TUSER_W];
    assign w_skid_vld = (r_state == PKT) & w_sel_vld;
    assign w_beat     = w_skid_vld & w_skid_rdy;

    // Only the granted source ever sees ready; everyone else waits with tvalid held.
    always_comb begin
        s_tready = '0;
        if (r_state == PKT)
            s_tready[r_grant_idx] = w_skid_rdy;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_grant_vld <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arb_en && |s_tvalid) begin
                        r_grant_idx <= IDX_W'(rr_pick(RR_MAX_SRC'(s_tvalid), RR_PTR_W'(r_rr_ptr), N_SRC));
                        r_grant_vld <= 1'b1;
                        r_state     <= PKT;
                    end
                end
                PKT: begin
                    if (w_beat && w_sel_last) begin
                        r_rr_ptr    <= (r_grant_idx == IDX_W'(N_SRC - 1)) ? '0 : r_grant_idx + 1'b1;
                        r_grant_vld <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_vld = r_grant_vld;
    assign grant_idx = r_grant_idx;

    axis_skid_buf #(
        .TDATA_W(TDATA_W),
        .TUSER_W(TUSER_W)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .s_tvalid(w_skid_vld),
        .s_tready(w_skid_rdy),
        .s_tdata (w_sel_data),
        .s_tuser (w_sel_user),
        .s_tlast (w_sel_last),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata (m_tdata),
        .m_tuser (m_tuser),
        .m_tlast (m_tlast)
    );

endmodule
